entry_alloc16: RTL and testbench

ENTRY_ALLOC16 -- requirements
Module: entry_alloc16

---
 rtl/entry_alloc16.sv | 81 ++++++++
 tb/tb_entry_alloc16.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/entry_alloc16.sv
// rtl/entry_alloc16.sv - 16-entry free-list allocator with one-cycle alloc/free and occupancy tracking
// Optional round-robin search enabled by defining ALLOC_RR_EN; default is fixed lowest-index priority.
module entry_alloc16 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        alloc_req,
    output logic        alloc_gnt,
    output logic [3:0]  alloc_idx,
    output logic [15:0] alloc_onehot,
    input  logic        free_valid,
    input  logic [3:0]  free_idx,
    output logic        free_err,
    output logic [15:0] used_map,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty
);

    logic [3:0]  ptr;
    logic [3:0]  sel_idx;
    logic [3:0]  cand;
    logic        found;
    logic        free_ok;
    logic [15:0] set_mask;
    logic [15:0] clr_mask;

    // Search starts at ptr and wraps; with ptr tied to 0 this is plain lowest-free priority.
    always_comb begin
        found   = 1'b0;
        sel_idx = 4'd0;
        cand    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cand = ptr + 4'(i);
            if (!found && !used_map[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign alloc_gnt    = alloc_req && found;
    assign alloc_idx    = alloc_gnt ? sel_idx : 4'd0;
    assign alloc_onehot = alloc_gnt ? (16'd1 << sel_idx) : 16'd0;

    // A freed entry is still marked used during the search, so it cannot be re-granted this cycle.
    assign free_ok  = free_valid && used_map[free_idx];
    assign set_mask = alloc_onehot;
    assign clr_mask = free_ok ? (16'd1 << free_idx) : 16'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            used_map <= 16'd0;
            count    <= 5'd0;
            free_err <= 1'b0;
        end else begin
            used_map <= (used_map | set_mask) & ~clr_mask;
            free_err <= free_valid && !used_map[free_idx];
            case ({alloc_gnt, free_ok})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef ALLOC_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= 4'd0;
        end else if (alloc_gnt) begin
            ptr <= sel_idx + 4'd1;
        end
    end
`else
    assign ptr = 4'd0;
`endif

    assign full  = (count == 5'd16);
    assign empty = (count == 5'd0);

endmodule

// File: tb/tb_entry_alloc16.sv
// tb/tb_entry_alloc16.sv - directed and randomised checks for entry_alloc16 (honours ALLOC_RR_EN)
module tb_entry_alloc16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [3:0]  alloc_idx;
    logic [15:0] alloc_onehot;
    logic        free_valid;
    logic [3:0]  free_idx;
    logic        free_err;
    logic [15:0] used_map;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int n_checks = 0;
    int n_pass   = 0;

    entry_alloc16 dut (
        .clk          (clk),
        .resetn       (resetn),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_idx    (alloc_idx),
        .alloc_onehot (alloc_onehot),
        .free_valid   (free_valid),
        .free_idx     (free_idx),
        .free_err     (free_err),
        .used_map     (used_map),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_idx   = 4'd0;
        resetn     = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic alloc_one(input string tag, input logic [3:0] exp_idx);
        alloc_req  = 1'b1;
        free_valid = 1'b0;
        #1;
        check({tag, "_gnt"}, 32'(alloc_gnt), 32'd1);
        check({tag, "_idx"}, 32'(alloc_idx), 32'(exp_idx));
        step();
        alloc_req = 1'b0;
    endtask

    task automatic free_one(input logic [3:0] idx);
        alloc_req  = 1'b0;
        free_valid = 1'b1;
        free_idx   = idx;
        step();
        free_valid = 1'b0;
    endtask

    logic [15:0] m_map;
    logic [3:0]  m_ptr;
    logic        m_err;
    logic        e_gnt;
    logic [3:0]  e_idx;
    logic [3:0]  c;

    initial begin
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_idx   = 4'd0;
        resetn     = 1'b0;
        #12;
        check("rst_used_map", 32'(used_map), 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_free_err", 32'(free_err), 32'd0);
        check("rst_gnt_idle", 32'(alloc_gnt), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        step();

        // fill 0..15 in order
        for (int i = 0; i < 16; i++) begin
            alloc_req = 1'b1;
            #1;
            check("fill_gnt", 32'(alloc_gnt), 32'd1);
            check("fill_idx", 32'(alloc_idx), 32'(i));
            check("fill_onehot", 32'(alloc_onehot), 32'(16'd1 << i));
            step();
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd16);
        check("full_map", 32'(used_map), 32'hffff);
        #1;
        check("full_req_gnt", 32'(alloc_gnt), 32'd0);
        check("full_req_idx", 32'(alloc_idx), 32'd0);
        check("full_req_onehot", 32'(alloc_onehot), 32'd0);
        step();
        alloc_req = 1'b0;
        check("full_req_count", 32'(count), 32'd16);

        // free 5 then re-grant 5
        free_one(4'd5);
        check("free5_count", 32'(count), 32'd15);
        check("free5_map", 32'(used_map), 32'hffdf);
        check("free5_err", 32'(free_err), 32'd0);
        alloc_one("regrant5", 4'd5);
        check("regrant5_full", 32'(full), 32'd1);

        // double free of 5
        free_one(4'd5);
        check("dfree1_err", 32'(free_err), 32'd0);
        free_one(4'd5);
        check("dfree2_err", 32'(free_err), 32'd1);
        check("dfree2_count", 32'(count), 32'd15);
        check("dfree2_map", 32'(used_map), 32'hffdf);
        step();
        check("dfree_err_clear", 32'(free_err), 32'd0);

        // async reset mid-burst at count=7
        do_reset();
        for (int i = 0; i < 7; i++) alloc_one("burst", 4'(i));
        check("burst_count", 32'(count), 32'd7);
        alloc_req = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("async_map", 32'(used_map), 32'h0);
        check("async_empty", 32'(empty), 32'd1);
        check("async_count", 32'(count), 32'd0);
        alloc_req = 1'b0;
        step();
        resetn = 1'b1;
        step();
        alloc_one("post_rst", 4'd0);

        // simultaneous alloc and free with map 0x0003
        do_reset();
        alloc_one("pre_a", 4'd0);
        alloc_one("pre_b", 4'd1);
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_idx   = 4'd0;
        #1;
        check("simul_gnt", 32'(alloc_gnt), 32'd1);
        check("simul_idx", 32'(alloc_idx), 32'd2);
        step();
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        check("simul_map", 32'(used_map), 32'h0006);
        check("simul_count", 32'(count), 32'd2);

        // round-robin vs fixed priority
        do_reset();
        alloc_one("rr_a", 4'd0);
        alloc_one("rr_b", 4'd1);
        free_one(4'd0);
`ifdef ALLOC_RR_EN
        alloc_one("rr_next", 4'd2);
`else
        alloc_one("fp_next", 4'd0);
`endif

        // random traffic against a reference model
        do_reset();
        m_map = 16'h0;
        m_ptr = 4'd0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            alloc_req  = ($urandom_range(0, 99) < 55);
            free_valid = ($urandom_range(0, 99) < 45);
            free_idx   = 4'($urandom_range(0, 15));
            e_gnt = 1'b0;
            e_idx = 4'd0;
            for (int i = 0; i < 16; i++) begin
                c = m_ptr + 4'(i);
                if (!e_gnt && !m_map[c]) begin
                    e_gnt = 1'b1;
                    e_idx = c;
                end
            end
            e_gnt = e_gnt && alloc_req;
            if (!e_gnt) e_idx = 4'd0;
            #1;
            check("rnd_gnt", 32'(alloc_gnt), 32'(e_gnt));
            check("rnd_idx", 32'(alloc_idx), 32'(e_idx));
            check("rnd_onehot", 32'(alloc_onehot), e_gnt ? 32'(16'd1 << e_idx) : 32'd0);
            check("rnd_map", 32'(used_map), 32'(m_map));
            check("rnd_count", 32'(count), 32'($countones(m_map)));
            check("rnd_err", 32'(free_err), 32'(m_err));
            m_err = free_valid && !m_map[free_idx];
            if (free_valid && m_map[free_idx]) m_map[free_idx] = 1'b0;
            if (e_gnt) begin
                m_map[e_idx] = 1'b1;
`ifdef ALLOC_RR_EN
                m_ptr = e_idx + 4'd1;
`endif
            end
            step();
        end
        alloc_req  = 1'b0;
        free_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
